mips_mc_controller: RTL and testbench

//  Control FSM for the multi-cycle MIPS core. Sits beside the datapath: it takes
//  op, funct and zero from the datapath and drives every datapath select/enable

---
 rtl/mips_mc_if.sv | 33 +++
 rtl/mips_mc_controller.sv | 162 ++++++++++++++++
 tb/tb_mips_mc_controller.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_mc_if.sv
// Datapath <-> control-FSM bundle for the multi-cycle MIPS core.
// master = controller (drives selects/enables), slave = datapath.
interface mips_mc_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       memready;
   logic       pcen;
   logic       memwrite;
   logic       iord;
   logic       irwrite;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [2:0] alucontrol;
   logic [1:0] pcsrc;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  op, funct, zero, memready,
      output pcen, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, alucontrol, pcsrc, illegal, state
   );

   modport slave (
      output op, funct, zero, memready,
      input  pcen, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, alucontrol, pcsrc, illegal, state
   );
endinterface

// File: rtl/mips_mc_controller.sv
// Moore control FSM for the multi-cycle MIPS datapath, with memready stalls
// on instruction fetch and data access.
module mips_mc_controller #(
   parameter bit ILLEGAL_TRAP = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   mips_mc_if.master  bus
);
   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMRD    = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWR    = 4'd5;
   localparam logic [3:0] S_EXECUTE  = 4'd6;
   localparam logic [3:0] S_ALUWB    = 4'd7;
   localparam logic [3:0] S_BRANCH   = 4'd8;
   localparam logic [3:0] S_ADDIEXEC = 4'd9;
   localparam logic [3:0] S_ADDIWB   = 4'd10;
   localparam logic [3:0] S_JUMP     = 4'd11;
   localparam logic [3:0] S_HALT     = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   logic [3:0] st, nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) st <= S_FETCH;
      else       st <= nxt;
   end

   always_comb begin
      nxt = st;
      case (st)
         S_FETCH:  if (bus.memready) nxt = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_RTYPE:     nxt = S_EXECUTE;
               OP_BEQ:       nxt = S_BRANCH;
               OP_ADDI:      nxt = S_ADDIEXEC;
               OP_J:         nxt = S_JUMP;
               default:      nxt = ILLEGAL_TRAP ? S_HALT : S_FETCH;
            endcase
         end
         S_MEMADR:   nxt = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:    if (bus.memready) nxt = S_MEMWB;
         S_MEMWB:    nxt = S_FETCH;
         S_MEMWR:    if (bus.memready) nxt = S_FETCH;
         S_EXECUTE:  nxt = S_ALUWB;
         S_ALUWB:    nxt = S_FETCH;
         S_BRANCH:   nxt = S_FETCH;
         S_ADDIEXEC: nxt = S_ADDIWB;
         S_ADDIWB:   nxt = S_FETCH;
         S_JUMP:     nxt = S_FETCH;
         S_HALT:     nxt = S_HALT;
         default:    nxt = S_FETCH;
      endcase
   end

   logic       pcwrite, branch, memwrite_d, irwrite_d, regwrite_d;
   logic       iord_d, regdst_d, memtoreg_d, alusrca_d, illegal_d;
   logic [1:0] alusrcb_d, pcsrc_d;
   logic [2:0] alucontrol_d;

   always_comb begin
      pcwrite      = 1'b0;
      branch       = 1'b0;
      memwrite_d   = 1'b0;
      irwrite_d    = 1'b0;
      regwrite_d   = 1'b0;
      iord_d       = 1'b0;
      regdst_d     = 1'b0;
      memtoreg_d   = 1'b0;
      alusrca_d    = 1'b0;
      illegal_d    = 1'b0;
      alusrcb_d    = 2'b00;
      pcsrc_d      = 2'b00;
      alucontrol_d = ALU_ADD;
      case (st)
         S_FETCH: begin
            // PC and IR only advance once the fetch has actually completed.
            alusrcb_d = 2'b01;
            irwrite_d = bus.memready;
            pcwrite   = bus.memready;
         end
         S_DECODE:   alusrcb_d = 2'b11;
         S_MEMADR: begin
            alusrca_d = 1'b1;
            alusrcb_d = 2'b10;
         end
         S_MEMRD:    iord_d = 1'b1;
         S_MEMWB: begin
            memtoreg_d = 1'b1;
            regwrite_d = 1'b1;
         end
         S_MEMWR: begin
            iord_d     = 1'b1;
            memwrite_d = 1'b1;
         end
         S_EXECUTE: begin
            alusrca_d = 1'b1;
            case (bus.funct)
               6'b100010: alucontrol_d = ALU_SUB;
               6'b100100: alucontrol_d = ALU_AND;
               6'b100101: alucontrol_d = ALU_OR;
               6'b101010: alucontrol_d = ALU_SLT;
               default:   alucontrol_d = ALU_ADD;
            endcase
         end
         S_ALUWB: begin
            regdst_d   = 1'b1;
            regwrite_d = 1'b1;
         end
         S_BRANCH: begin
            alusrca_d    = 1'b1;
            alucontrol_d = ALU_SUB;
            pcsrc_d      = 2'b01;
            branch       = 1'b1;
         end
         S_ADDIEXEC: begin
            alusrca_d = 1'b1;
            alusrcb_d = 2'b10;
         end
         S_ADDIWB:   regwrite_d = 1'b1;
         S_JUMP: begin
            pcsrc_d = 2'b10;
            pcwrite = 1'b1;
         end
         S_HALT:     illegal_d = 1'b1;
         default: ;
      endcase
   end

   // State is already FETCH while reset is high, so only the write enables
   // need explicit gating (FETCH's irwrite/pcen follow memready otherwise).
   assign bus.pcen       = ~reset & (pcwrite | (branch & bus.zero));
   assign bus.irwrite    = ~reset & irwrite_d;
   assign bus.regwrite   = ~reset & regwrite_d;
   assign bus.memwrite   = ~reset & memwrite_d;
   assign bus.iord       = iord_d;
   assign bus.regdst     = regdst_d;
   assign bus.memtoreg   = memtoreg_d;
   assign bus.alusrca    = alusrca_d;
   assign bus.alusrcb    = alusrcb_d;
   assign bus.alucontrol = alucontrol_d;
   assign bus.pcsrc      = pcsrc_d;
   assign bus.illegal    = illegal_d;
   assign bus.state      = st;
endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: two instances (NOP and trap on illegal op)
// checked cycle by cycle against an instruction-path reference model.
module tb_mips_mc_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mips_mc_if bus0 ();
   mips_mc_if bus1 ();

   mips_mc_controller #(.ILLEGAL_TRAP(1'b0)) dut0 (.clk(clk), .reset(rst), .bus(bus0));
   mips_mc_controller #(.ILLEGAL_TRAP(1'b1)) dut1 (.clk(clk), .reset(rst), .bus(bus1));

   typedef struct packed {
      logic       pcen, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca;
      logic [1:0] alusrcb;
      logic [2:0] alucontrol;
      logic [1:0] pcsrc;
      logic       illegal;
      logic [3:0] state;
   } ctl_t;

   ctl_t obs0, obs1;
   assign obs0 = {bus0.pcen, bus0.memwrite, bus0.iord, bus0.irwrite, bus0.regdst,
                  bus0.memtoreg, bus0.regwrite, bus0.alusrca, bus0.alusrcb,
                  bus0.alucontrol, bus0.pcsrc, bus0.illegal, bus0.state};
   assign obs1 = {bus1.pcen, bus1.memwrite, bus1.iord, bus1.irwrite, bus1.regdst,
                  bus1.memtoreg, bus1.regwrite, bus1.alusrca, bus1.alusrcb,
                  bus1.alucontrol, bus1.pcsrc, bus1.illegal, bus1.state};

   int errors = 0;
   int checks = 0;

   // Expected control word for a state, written straight from the per-state table.
   function automatic ctl_t model(input int st, input logic [5:0] fn, input logic z,
                                  input logic mr, input logic rs);
      ctl_t c;
      c = '0;
      c.alucontrol = 3'b010;
      c.state = st[3:0];
      case (st)
         0:  begin c.alusrcb = 2'b01; c.irwrite = mr; c.pcen = mr; end
         1:  c.alusrcb = 2'b11;
         2:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         3:  c.iord = 1'b1;
         4:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
         5:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
         6:  begin
                c.alusrca = 1'b1;
                c.alucontrol = (fn == 6'b100010) ? 3'b110 :
                               (fn == 6'b100100) ? 3'b000 :
                               (fn == 6'b100101) ? 3'b001 :
                               (fn == 6'b101010) ? 3'b111 : 3'b010;
             end
         7:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
         8:  begin c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = z; end
         9:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         10: c.regwrite = 1'b1;
         11: begin c.pcsrc = 2'b10; c.pcen = 1'b1; end
         12: c.illegal = 1'b1;
         default: ;
      endcase
      if (rs) begin
         c.pcen = 1'b0; c.irwrite = 1'b0; c.regwrite = 1'b0; c.memwrite = 1'b0;
      end
      return c;
   endfunction

   task automatic chk(input int which, input ctl_t e, input string tag);
      ctl_t o;
      o = (which == 0) ? obs0 : obs1;
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, which, o, e);
      end
   endtask

   task automatic drive(input logic [5:0] o, input logic [5:0] fn, input logic z, input logic mr);
      bus0.op = o; bus0.funct = fn; bus0.zero = z; bus0.memready = mr;
      bus1.op = o; bus1.funct = fn; bus1.zero = z; bus1.memready = mr;
   endtask

   // One clock: drive at negedge, check both instances, then the posedge follows.
   task automatic cyc(input int st0, input int st1, input logic [5:0] o, input logic [5:0] fn,
                      input logic z, input logic mr, input string tag);
      @(negedge clk);
      drive(o, fn, z, mr);
      #1;
      chk(0, model(st0, fn, z, mr, 1'b0), tag);
      chk(1, model(st1, fn, z, mr, 1'b0), tag);
   endtask

   // Random instruction: state path from the instruction class, stalls in memory states.
   task automatic run_instr();
      int k, stalls;
      bit done, is_mem;
      logic mr, z;
      logic [5:0] o, fn;
      int path[$];
      logic [5:0] fns[6];
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
      fns[5] = 6'($urandom);
      fn = fns[$urandom_range(0, 5)];
      k = $urandom_range(0, 5);
      case (k)
         0: begin o = 6'b100011; path = '{0, 1, 2, 3, 4}; end
         1: begin o = 6'b101011; path = '{0, 1, 2, 5}; end
         2: begin o = 6'b000000; path = '{0, 1, 6, 7}; end
         3: begin o = 6'b000100; path = '{0, 1, 8}; end
         4: begin o = 6'b001000; path = '{0, 1, 9, 10}; end
         default: begin o = 6'b000010; path = '{0, 1, 11}; end
      endcase
      foreach (path[i]) begin
         stalls = 0;
         done = 1'b0;
         is_mem = (path[i] == 0) || (path[i] == 3) || (path[i] == 5);
         while (!done) begin
            if (is_mem) mr = (stalls >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
            else        mr = 1'($urandom_range(0, 1));
            z = 1'($urandom_range(0, 1));
            cyc(path[i], path[i], o, fn, z, mr, "rand");
            if (is_mem && !mr) stalls++;
            else done = 1'b1;
         end
      end
   endtask

   initial begin
      drive(6'b100011, 6'b0, 1'b0, 1'b1);
      #1;
      chk(0, model(0, 6'b0, 1'b0, 1'b1, 1'b1), "reset");
      chk(1, model(0, 6'b0, 1'b0, 1'b1, 1'b1), "reset");
      @(negedge clk);
      drive(6'b100011, 6'b0, 1'b0, 1'b0);
      rst = 1'b0;

      // lw, no stalls: 5 cycles
      cyc(0, 0, 6'b100011, 6'b0, 1'b0, 1'b1, "lw_fetch");
      cyc(1, 1, 6'b100011, 6'b0, 1'b0, 1'b1, "lw_decode");
      cyc(2, 2, 6'b100011, 6'b0, 1'b0, 1'b1, "lw_memadr");
      cyc(3, 3, 6'b100011, 6'b0, 1'b0, 1'b1, "lw_memrd");
      cyc(4, 4, 6'b100011, 6'b0, 1'b0, 1'b1, "lw_memwb");

      // sw, two stall cycles in MEMWR keep memwrite up for three cycles
      cyc(0, 0, 6'b101011, 6'b0, 1'b0, 1'b1, "sw_fetch");
      cyc(1, 1, 6'b101011, 6'b0, 1'b0, 1'b1, "sw_decode");
      cyc(2, 2, 6'b101011, 6'b0, 1'b0, 1'b1, "sw_memadr");
      cyc(5, 5, 6'b101011, 6'b0, 1'b0, 1'b0, "sw_stall1");
      cyc(5, 5, 6'b101011, 6'b0, 1'b0, 1'b0, "sw_stall2");
      cyc(5, 5, 6'b101011, 6'b0, 1'b0, 1'b1, "sw_done");

      // R-type slt
      cyc(0, 0, 6'b000000, 6'b101010, 1'b0, 1'b1, "slt_fetch");
      cyc(1, 1, 6'b000000, 6'b101010, 1'b0, 1'b1, "slt_decode");
      cyc(6, 6, 6'b000000, 6'b101010, 1'b0, 1'b1, "slt_exec");
      cyc(7, 7, 6'b000000, 6'b101010, 1'b0, 1'b1, "slt_wb");

      // beq taken then not taken
      cyc(0, 0, 6'b000100, 6'b0, 1'b0, 1'b1, "beq1_fetch");
      cyc(1, 1, 6'b000100, 6'b0, 1'b0, 1'b1, "beq1_decode");
      cyc(8, 8, 6'b000100, 6'b0, 1'b1, 1'b1, "beq_taken");
      cyc(0, 0, 6'b000100, 6'b0, 1'b0, 1'b1, "beq2_fetch");
      cyc(1, 1, 6'b000100, 6'b0, 1'b0, 1'b1, "beq2_decode");
      cyc(8, 8, 6'b000100, 6'b0, 1'b0, 1'b1, "beq_not_taken");

      // fetch stalled three cycles, then j
      cyc(0, 0, 6'b000010, 6'b0, 1'b0, 1'b0, "fetch_stall1");
      cyc(0, 0, 6'b000010, 6'b0, 1'b0, 1'b0, "fetch_stall2");
      cyc(0, 0, 6'b000010, 6'b0, 1'b0, 1'b0, "fetch_stall3");
      cyc(0, 0, 6'b000010, 6'b0, 1'b0, 1'b1, "fetch_go");
      cyc(1, 1, 6'b000010, 6'b0, 1'b0, 1'b1, "j_decode");
      cyc(11, 11, 6'b000010, 6'b0, 1'b0, 1'b1, "j_jump");

      for (int n = 0; n < 60; n++) run_instr();

      // unsupported op: NOP on dut0, HALT on dut1
      cyc(0, 0, 6'b111111, 6'b0, 1'b0, 1'b1, "ill_fetch");
      cyc(1, 1, 6'b111111, 6'b0, 1'b0, 1'b1, "ill_decode");
      cyc(0, 12, 6'b111111, 6'b0, 1'b0, 1'b1, "ill_halt1");
      cyc(1, 12, 6'b111111, 6'b0, 1'b0, 1'b1, "ill_halt2");
      cyc(0, 12, 6'b111111, 6'b0, 1'b1, 1'b1, "ill_halt3");

      @(negedge clk);
      rst = 1'b1;
      drive(6'b100011, 6'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // reset asserted mid-cycle in MEMRD takes effect without a clock edge
      cyc(0, 0, 6'b100011, 6'b0, 1'b0, 1'b1, "rst_fetch");
      cyc(1, 1, 6'b100011, 6'b0, 1'b0, 1'b1, "rst_decode");
      cyc(2, 2, 6'b100011, 6'b0, 1'b0, 1'b1, "rst_memadr");
      cyc(3, 3, 6'b100011, 6'b0, 1'b0, 1'b0, "rst_memrd");
      rst = 1'b1;
      drive(6'b100011, 6'b0, 1'b0, 1'b1);
      #1;
      chk(0, model(0, 6'b0, 1'b0, 1'b1, 1'b1), "async_reset");
      chk(1, model(0, 6'b0, 1'b0, 1'b1, 1'b1), "async_reset");
      @(negedge clk);
      drive(6'b100011, 6'b0, 1'b0, 1'b0);
      rst = 1'b0;
      cyc(0, 0, 6'b100011, 6'b0, 1'b0, 1'b1, "post_reset_fetch");
      cyc(1, 1, 6'b100011, 6'b0, 1'b0, 1'b1, "post_reset_decode");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
